// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU operation codes, FSM states and decoded instruction classes.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

    typedef enum logic [2:0] {
        IC_RTYPE,
        IC_ADDI,
        IC_LW,
        IC_SW,
        IC_BEQ,
        IC_J,
        IC_ILLEGAL
    } iclass_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// Combinational instruction decode: opcode/funct to ALU control, operand
// select and instruction class (IC_ILLEGAL for anything unsupported).
module mips_multicycle_ctrl_alu_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       alu_src,
    output iclass_e    iclass,
    output logic       legal
);

    always_comb begin
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        iclass  = IC_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                iclass = IC_RTYPE;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: iclass = IC_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                iclass  = IC_ADDI;
                alu_src = 1'b1;
            end
            OP_LW: begin
                iclass  = IC_LW;
                alu_src = 1'b1;
            end
            OP_SW: begin
                iclass  = IC_SW;
                alu_src = 1'b1;
            end
            OP_BEQ: begin
                iclass = IC_BEQ;
                alu_op = ALU_SUB;
            end
            OP_J:    iclass = IC_J;
            default: iclass = IC_ILLEGAL;
        endcase
    end

    assign legal = (iclass != IC_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: fetch handshake, decode, execute, data memory
// and register writeback around an external ALU and register file. Owns the PC.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        illegal_instr,
    output logic        bus_err
);

    localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       aluout_q, aluout_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       mdr_q, mdr_d;

    logic [3:0]  dec_alu_op;
    logic        dec_alu_src;
    iclass_e     iclass;
    logic        dec_legal;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    mips_multicycle_ctrl_alu_decode u_alu_decode (
        .opcode  (ir_q[31:26]),
        .funct   (ir_q[5:0]),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .iclass  (iclass),
        .legal   (dec_legal)
    );

    assign imm_ext       = sign_ext16(ir_q[15:0]);
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath holding registers; only meaningful once the FSM has loaded them.
    always_ff @(posedge clk) begin
        ir_q     <= ir_d;
        aluout_q <= aluout_d;
        b_q      <= b_d;
        mdr_q    <= mdr_d;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        ir_d     = ir_q;
        aluout_d = aluout_q;
        b_d      = b_q;
        mdr_d    = mdr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (iclass)
                    IC_J: begin
                        pc_d    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                        state_d = ST_IDLE;
                    end
                    IC_ILLEGAL: begin
                        pc_d    = pc_plus4;
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                aluout_d = alu_result;
                b_d      = rt_data;
                case (iclass)
                    IC_BEQ: begin
                        pc_d    = (alu_result == 32'd0) ? branch_target : pc_plus4;
                        state_d = ST_IDLE;
                    end
                    IC_LW, IC_SW: begin
                        cnt_d   = '0;
                        state_d = ST_MEM;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // An ack arriving on the final timeout cycle still completes the access.
                if (mem_ack) begin
                    if (iclass == IC_SW) begin
                        pc_d    = pc_plus4;
                        state_d = ST_IDLE;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = ST_WB;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                pc_d    = pc_plus4;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready   = (state_q == ST_IDLE);
        alu_op        = ALU_ADD;
        alu_src       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        rf_we         = 1'b0;
        illegal_instr = 1'b0;
        bus_err       = 1'b0;
        rf_waddr      = (iclass == IC_RTYPE) ? ir_q[15:11] : ir_q[20:16];
        rf_wdata      = (iclass == IC_LW) ? mdr_q : aluout_q;
        case (state_q)
            ST_DECODE: begin
                alu_op        = dec_alu_op;
                alu_src       = dec_alu_src;
                illegal_instr = !dec_legal;
            end
            ST_EXEC: begin
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (iclass == IC_SW);
                bus_err = !mem_ack && (cnt_q == CNT_LAST);
            end
            ST_WB:   rf_we = (rf_waddr != 5'd0);
            default: ;
        endcase
    end

    assign pc        = pc_q;
    assign rs_addr   = ir_q[25:21];
    assign rt_addr   = ir_q[20:16];
    assign mem_addr  = aluout_q;
    assign mem_wdata = b_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: bench-side register file, ALU
// and memory responder, with an instruction-level reference model.
module tb_mips_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        illegal_instr, bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] regs [32];

    typedef struct {
        int          wr_cnt;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          wr_cycle;
        int          mem_cycles;
        logic        mem_we;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        int          illegal;
        int          buserr;
        logic [31:0] pc;
        int          done;
        logic [3:0]  dec_alu_op;
        logic        dec_alu_src;
    } res_t;

    res_t obs, exp_r;

    mips_multicycle_ctrl #(.PC_RESET(32'h0000_0000), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .alu_op(alu_op), .alu_src(alu_src),
        .imm_ext(imm_ext), .alu_result(alu_result), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .illegal_instr(illegal_instr), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];

    // Environment ALU driven by the controller's alu_op / alu_src.
    logic [31:0] opb;
    always_comb begin
        opb = alu_src ? imm_ext : rt_data;
        case (alu_op)
            4'b0010: alu_result = rs_data + opb;
            4'b0110: alu_result = rs_data - opb;
            4'b0000: alu_result = rs_data & opb;
            4'b0001: alu_result = rs_data | opb;
            4'b1100: alu_result = ~(rs_data | opb);
            4'b0111: alu_result = ($signed(rs_data) < $signed(opb)) ? 32'd1 : 32'd0;
            default: alu_result = 32'hBAD0_BAD0;
        endcase
    end

    // Architectural effect of one instruction, from MIPS semantics and the
    // documented cycle timing (DECODE=1, EXEC=2, MEM=3.., WB after MEM/EXEC).
    function automatic res_t model_instr(input logic [31:0] ins, input int ack_after,
                                         input logic [31:0] rdata, input logic [31:0] pc0);
        res_t r;
        logic [31:0] a, b, se, p4;
        r = '{default: 0};
        a  = regs[ins[25:21]];
        b  = regs[ins[20:16]];
        se = {{16{ins[15]}}, ins[15:0]};
        p4 = pc0 + 32'd4;
        r.pc   = p4;
        r.done = 4;
        case (ins[31:26])
            6'h00: begin
                r.waddr = ins[15:11];
                case (ins[5:0])
                    6'h20: r.wdata = a + b;
                    6'h22: r.wdata = a - b;
                    6'h24: r.wdata = a & b;
                    6'h25: r.wdata = a | b;
                    6'h27: r.wdata = ~(a | b);
                    6'h2A: r.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin
                        r.illegal = 1;
                        r.done    = 2;
                    end
                endcase
                if (r.illegal == 0) begin
                    r.wr_cnt   = (r.waddr != 5'd0) ? 1 : 0;
                    r.wr_cycle = 3;
                end
            end
            6'h08: begin
                r.waddr    = ins[20:16];
                r.wdata    = a + se;
                r.wr_cnt   = (r.waddr != 5'd0) ? 1 : 0;
                r.wr_cycle = 3;
            end
            6'h23, 6'h2B: begin
                r.maddr  = a + se;
                r.mem_we = (ins[31:26] == 6'h2B);
                r.mwdata = b;
                if (ack_after >= 1 && ack_after <= TIMEOUT) begin
                    r.mem_cycles = ack_after;
                    if (ins[31:26] == 6'h23) begin
                        r.waddr    = ins[20:16];
                        r.wdata    = rdata;
                        r.wr_cnt   = (r.waddr != 5'd0) ? 1 : 0;
                        r.wr_cycle = 3 + ack_after;
                        r.done     = 4 + ack_after;
                    end else begin
                        r.done = 3 + ack_after;
                    end
                end else begin
                    r.mem_cycles = TIMEOUT;
                    r.buserr     = 1;
                    r.pc         = pc0;
                    r.done       = 3 + TIMEOUT;
                end
            end
            6'h04: begin
                r.pc   = (a == b) ? p4 + (se << 2) : p4;
                r.done = 3;
            end
            6'h02: begin
                r.pc   = {p4[31:28], ins[25:0], 2'b00};
                r.done = 2;
            end
            default: begin
                r.illegal = 1;
                r.done    = 2;
            end
        endcase
        return r;
    endfunction

    task automatic reset_dut();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Offers one instruction, plays memory, mirrors rf writes into regs, records observations.
    task automatic drive_instr(input logic [31:0] ins, input int ack_after,
                               input logic [31:0] rdata, input bit hold_valid);
        int waited;
        obs = '{default: 0};
        obs.done = -1;
        waited = 0;
        @(negedge clk); #1;
        while (!instr_ready && waited < 40) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!instr_ready) begin
            n_tests++; n_fail++;
            $display("FAIL ready_wait: instr_ready=%0b required 1", instr_ready);
            return;
        end
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk); #1;
        instr_valid = hold_valid;
        instr       = hold_valid ? 32'hFC00_0000 : $urandom;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                obs.mem_cycles++;
                if (ack_after != 0 && obs.mem_cycles == ack_after) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_rdata = $urandom;
                end
            end
            #1;
            if (k == 1) begin
                obs.dec_alu_op  = alu_op;
                obs.dec_alu_src = alu_src;
            end
            if (mem_req) begin
                obs.maddr  = mem_addr;
                obs.mem_we = mem_we;
                obs.mwdata = mem_wdata;
            end
            if (rf_we) begin
                obs.wr_cnt++;
                obs.waddr    = rf_waddr;
                obs.wdata    = rf_wdata;
                obs.wr_cycle = k;
                if (rf_waddr != 5'd0) regs[rf_waddr] = rf_wdata;
            end
            if (illegal_instr) obs.illegal++;
            if (bus_err) obs.buserr++;
            if (instr_ready) begin
                obs.done    = k;
                instr_valid = 1'b0;
                break;
            end
        end
        mem_ack = 1'b0;
        obs.pc  = pc;
    endtask

    task automatic test_reset();
        reset_dut();
        drive_instr(32'h0800_0010, 0, 32'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_tests++; if (alu_op !== 4'b0010) begin n_fail++; $display("FAIL reset_alu_op: got %b want 0010", alu_op); end
        n_tests++; if (alu_src !== 1'b0) begin n_fail++; $display("FAIL reset_alu_src: got %b want 0", alu_src); end
        rst_n = 1'b1;
    endtask

    task automatic test_r_add();
        reset_dut();
        regs[1] = 32'd5; regs[2] = 32'd7;
        drive_instr(32'h0022_1820, 0, 32'd0, 1'b0);
        n_tests++; if (obs.dec_alu_op !== 4'b0010) begin n_fail++; $display("FAIL add_alu_op: got %b want 0010", obs.dec_alu_op); end
        n_tests++; if (obs.wr_cnt !== 1 || obs.waddr !== 5'd3 || obs.wdata !== 32'd12)
            begin n_fail++; $display("FAIL add_wb: cnt=%0d addr=%0d data=%0d want 1/3/12", obs.wr_cnt, obs.waddr, obs.wdata); end
        n_tests++; if (obs.wr_cycle !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", obs.wr_cycle); end
        n_tests++; if (obs.pc !== 32'd4) begin n_fail++; $display("FAIL add_pc: got %h want 00000004", obs.pc); end
        drive_instr(32'h0022_202A, 0, 32'd0, 1'b0);
        n_tests++; if (obs.dec_alu_op !== 4'b0111 || obs.wdata !== 32'd1)
            begin n_fail++; $display("FAIL slt: op=%b data=%0d want 0111/1", obs.dec_alu_op, obs.wdata); end
    endtask

    task automatic test_beq();
        reset_dut();
        regs[1] = 32'd9; regs[2] = 32'd9;
        drive_instr(32'h1022_0003, 0, 32'd0, 1'b0);
        n_tests++; if (obs.pc !== 32'd16) begin n_fail++; $display("FAIL beq_taken_pc: got %h want 00000010", obs.pc); end
        n_tests++; if (obs.wr_cnt !== 0 || obs.done !== 3)
            begin n_fail++; $display("FAIL beq_taken_seq: wr=%0d done=%0d want 0/3", obs.wr_cnt, obs.done); end
        reset_dut();
        regs[2] = 32'd10;
        drive_instr(32'h1022_0003, 0, 32'd0, 1'b0);
        n_tests++; if (obs.pc !== 32'd4 || obs.wr_cnt !== 0)
            begin n_fail++; $display("FAIL beq_not_taken: pc=%h wr=%0d want 00000004/0", obs.pc, obs.wr_cnt); end
    endtask

    task automatic test_lw();
        reset_dut();
        regs[1] = 32'h100;
        drive_instr(32'h8C25_0008, 3, 32'hDEAD_BEEF, 1'b0);
        n_tests++; if (obs.maddr !== 32'h108 || obs.mem_we !== 1'b0 || obs.mem_cycles !== 3)
            begin n_fail++; $display("FAIL lw_mem: addr=%h we=%b cyc=%0d want 108/0/3", obs.maddr, obs.mem_we, obs.mem_cycles); end
        n_tests++; if (obs.dec_alu_src !== 1'b1) begin n_fail++; $display("FAIL lw_alu_src: got %b want 1", obs.dec_alu_src); end
        n_tests++; if (obs.wr_cnt !== 1 || obs.waddr !== 5'd5 || obs.wdata !== 32'hDEAD_BEEF)
            begin n_fail++; $display("FAIL lw_wb: cnt=%0d addr=%0d data=%h want 1/5/deadbeef", obs.wr_cnt, obs.waddr, obs.wdata); end
        n_tests++; if (obs.pc !== 32'd4) begin n_fail++; $display("FAIL lw_pc: got %h want 00000004", obs.pc); end
    endtask

    task automatic test_timeout();
        reset_dut();
        regs[1] = 32'h40; regs[2] = 32'h1234_5678;
        drive_instr(32'hAC22_0004, 0, 32'd0, 1'b0);
        n_tests++; if (obs.buserr !== 1 || obs.mem_cycles !== TIMEOUT)
            begin n_fail++; $display("FAIL sw_timeout: buserr=%0d cyc=%0d want 1/%0d", obs.buserr, obs.mem_cycles, TIMEOUT); end
        n_tests++; if (obs.pc !== 32'd0 || obs.wr_cnt !== 0 || obs.done !== 3 + TIMEOUT)
            begin n_fail++; $display("FAIL sw_timeout_state: pc=%h wr=%0d done=%0d want 0/0/%0d", obs.pc, obs.wr_cnt, obs.done, 3 + TIMEOUT); end
        n_tests++; if (obs.mwdata !== 32'h1234_5678 || obs.mem_we !== 1'b1)
            begin n_fail++; $display("FAIL sw_wdata: data=%h we=%b want 12345678/1", obs.mwdata, obs.mem_we); end
        drive_instr(32'h8C25_0000, TIMEOUT, 32'hCAFE_F00D, 1'b0);
        n_tests++; if (obs.buserr !== 0 || obs.wr_cnt !== 1 || obs.wdata !== 32'hCAFE_F00D || obs.pc !== 32'd4)
            begin n_fail++; $display("FAIL ack_on_last: buserr=%0d wr=%0d data=%h pc=%h want 0/1/cafef00d/4", obs.buserr, obs.wr_cnt, obs.wdata, obs.pc); end
    endtask

    task automatic test_reset_mid_mem();
        int memc;
        reset_dut();
        drive_instr(32'h0800_0100, 0, 32'd0, 1'b0);
        regs[1] = 32'h80;
        @(negedge clk); #1;
        instr_valid = 1'b1; instr = 32'hAC22_0000;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        memc = 0;
        for (int k = 0; k < 30 && memc < 4; k++) begin
            @(negedge clk); #1;
            if (mem_req) memc++;
        end
        n_tests++; if (memc !== 4) begin n_fail++; $display("FAIL midmem_reach: mem cycles %0d want 4", memc); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (mem_req !== 1'b0 || instr_ready !== 1'b1 || pc !== 32'd0 || rf_we !== 1'b0)
            begin n_fail++; $display("FAIL midmem_reset: req=%b rdy=%b pc=%h we=%b want 0/1/0/0", mem_req, instr_ready, pc, rf_we); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        reset_dut();
        regs[1] = 32'd3;
        drive_instr(32'hFC00_0000, 0, 32'd0, 1'b0);
        n_tests++; if (obs.illegal !== 1 || obs.pc !== 32'd4 || obs.done !== 2)
            begin n_fail++; $display("FAIL illegal_op: pulses=%0d pc=%h done=%0d want 1/4/2", obs.illegal, obs.pc, obs.done); end
        drive_instr(32'h2020_0001, 0, 32'd0, 1'b0);
        n_tests++; if (obs.wr_cnt !== 0 || obs.pc !== 32'd8 || obs.illegal !== 0)
            begin n_fail++; $display("FAIL addi_r0: wr=%0d pc=%h ill=%0d want 0/8/0", obs.wr_cnt, obs.pc, obs.illegal); end
        drive_instr(32'h3022_00FF, 0, 32'd0, 1'b0);
        n_tests++; if (obs.illegal !== 1 || obs.wr_cnt !== 0 || obs.pc !== 32'd12)
            begin n_fail++; $display("FAIL andi_illegal: ill=%0d wr=%0d pc=%h want 1/0/c", obs.illegal, obs.wr_cnt, obs.pc); end
    endtask

    task automatic test_busy_ignore();
        reset_dut();
        regs[1] = 32'd20; regs[2] = 32'd22;
        drive_instr(32'h0022_1822, 0, 32'd0, 1'b1);
        n_tests++; if (obs.illegal !== 0 || obs.wdata !== 32'hFFFF_FFFE || obs.pc !== 32'd4)
            begin n_fail++; $display("FAIL busy_ignore: ill=%0d data=%h pc=%h want 0/fffffffe/4", obs.illegal, obs.wdata, obs.pc); end
        drive_instr(32'h0800_0000, 0, 32'd0, 1'b0);
        n_tests++; if (obs.pc !== 32'd0 || obs.illegal !== 0)
            begin n_fail++; $display("FAIL after_busy: pc=%h ill=%0d want 0/0", obs.pc, obs.illegal); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, ins, rdata;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fl [6];
        logic [5:0]  bad_op [6];
        logic [5:0]  bad_fn [4];
        int kind, ack;
        fl     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        bad_op = '{6'h3F, 6'h0C, 6'h0D, 6'h01, 6'h03, 6'h05};
        bad_fn = '{6'h21, 6'h23, 6'h00, 6'h08};
        reset_dut();
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        exp_pc = 32'd0;
        for (int n = 0; n < 60; n++) begin
            kind  = $urandom_range(0, 7);
            rs    = 5'($urandom_range(0, 31));
            rt    = 5'($urandom_range(0, 31));
            rd    = 5'($urandom_range(0, 31));
            rdata = $urandom;
            ack   = 0;
            case (kind)
                0, 1: ins = {6'h00, rs, rt, rd, 5'd0, fl[$urandom_range(0, 5)]};
                2:    ins = {6'h08, rs, rt, 16'($urandom)};
                3, 4: begin
                    ins = {(kind == 3) ? 6'h23 : 6'h2B, rs, rt, 16'($urandom)};
                    ack = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
                end
                5: begin
                    if ($urandom_range(0, 1) == 1) rt = rs;
                    ins = {6'h04, rs, rt, 16'($urandom)};
                end
                6: ins = {6'h02, 26'($urandom)};
                default: ins = ($urandom_range(0, 1) == 1) ?
                               {bad_op[$urandom_range(0, 5)], 26'($urandom)} :
                               {6'h00, rs, rt, rd, 5'd0, bad_fn[$urandom_range(0, 3)]};
            endcase
            exp_r = model_instr(ins, ack, rdata, exp_pc);
            drive_instr(ins, ack, rdata, 1'b0);
            n_tests++; if (obs.done !== exp_r.done || obs.pc !== exp_r.pc)
                begin n_fail++; $display("FAIL rnd_flow[%0d] ins=%h: done=%0d pc=%h want %0d/%h", n, ins, obs.done, obs.pc, exp_r.done, exp_r.pc); end
            n_tests++; if (obs.wr_cnt !== exp_r.wr_cnt)
                begin n_fail++; $display("FAIL rnd_wr_cnt[%0d] ins=%h: got %0d want %0d", n, ins, obs.wr_cnt, exp_r.wr_cnt); end
            if (exp_r.wr_cnt == 1) begin
                n_tests++; if (obs.waddr !== exp_r.waddr || obs.wdata !== exp_r.wdata || obs.wr_cycle !== exp_r.wr_cycle)
                    begin n_fail++; $display("FAIL rnd_wb[%0d] ins=%h: %0d/%h@%0d want %0d/%h@%0d", n, ins, obs.waddr, obs.wdata, obs.wr_cycle, exp_r.waddr, exp_r.wdata, exp_r.wr_cycle); end
            end
            n_tests++; if (obs.mem_cycles !== exp_r.mem_cycles || obs.illegal !== exp_r.illegal || obs.buserr !== exp_r.buserr)
                begin n_fail++; $display("FAIL rnd_ctrl[%0d] ins=%h: memc=%0d ill=%0d berr=%0d want %0d/%0d/%0d", n, ins, obs.mem_cycles, obs.illegal, obs.buserr, exp_r.mem_cycles, exp_r.illegal, exp_r.buserr); end
            if (exp_r.mem_cycles > 0) begin
                n_tests++; if (obs.maddr !== exp_r.maddr || obs.mem_we !== exp_r.mem_we || (exp_r.mem_we && obs.mwdata !== exp_r.mwdata))
                    begin n_fail++; $display("FAIL rnd_mem[%0d] ins=%h: addr=%h we=%b wd=%h want %h/%b/%h", n, ins, obs.maddr, obs.mem_we, obs.mwdata, exp_r.maddr, exp_r.mem_we, exp_r.mwdata); end
            end
            exp_pc = exp_r.pc;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        test_reset();
        test_r_add();
        test_beq();
        test_lw();
        test_timeout();
        test_reset_mid_mem();
        test_illegal();
        test_busy_ignore();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
